// File: rtl/ram_port_arbiter.sv
// Shares the single main-RAM port between cache refill/writeback bursts and an uncached single-word port.
// Optional starvation guard for the uncached port is enabled by defining ARB_FAIRNESS_EN.
module ram_port_arbiter #(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  c_req,
    input  logic                  c_we,
    input  logic                  c_last,
    input  logic [ADDR_W-1:0]     c_addr,
    input  logic [DATA_W-1:0]     c_wdata,
    output logic                  c_gnt,
    output logic                  c_rvalid,
    input  logic                  u_req,
    input  logic                  u_we,
    input  logic [DATA_W/8-1:0]   u_be,
    input  logic [ADDR_W-1:0]     u_addr,
    input  logic [DATA_W-1:0]     u_wdata,
    output logic                  u_ack,
    output logic [DATA_W-1:0]     u_rdata,
    output logic                  ram_en,
    output logic [DATA_W/8-1:0]   ram_we,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W-1:0]     ram_wdata,
    input  logic [DATA_W-1:0]     ram_rdata
);

    localparam int BE_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CACHE   = 2'd1,
        U_ISSUE = 2'd2,
        U_RESP  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic                latch_s;
    logic                u_first_s;
    logic                lat_we_r;
    logic [BE_W-1:0]     lat_be_r;
    logic [ADDR_W-1:0]   lat_addr_r;
    logic [DATA_W-1:0]   lat_wdata_r;
    logic                c_rvalid_r;

`ifdef ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0]    starve_cnt_r;

    // Starve counter: counts cycles the uncached port waits, saturating, cleared on its ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r == U_RESP) begin
            starve_cnt_r <= {CNT_W{1'b0}};
        end else if (u_req && (state_r != U_ISSUE) && (starve_cnt_r != LIMIT_C)) begin
            starve_cnt_r <= starve_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

    assign u_first_s = u_req && (starve_cnt_r == LIMIT_C);
`else
    logic starve_unused_s;

    assign starve_unused_s = (STARVE_LIMIT > 0);
    assign u_first_s       = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; cache has priority in IDLE unless the uncached port is starved.
    always_comb begin
        state_nxt_s = state_r;
        latch_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (u_first_s) begin
                    state_nxt_s = U_ISSUE;
                    latch_s     = 1'b1;
                end else if (c_req) begin
                    state_nxt_s = CACHE;
                end else if (u_req) begin
                    state_nxt_s = U_ISSUE;
                    latch_s     = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CACHE: begin
                if (c_req && c_last) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = CACHE;
                end
            end
            U_ISSUE: state_nxt_s = U_RESP;
            U_RESP:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Uncached request capture; later u_* changes are ignored until the next acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we_r    <= 1'b0;
            lat_be_r    <= {BE_W{1'b0}};
            lat_addr_r  <= {ADDR_W{1'b0}};
            lat_wdata_r <= {DATA_W{1'b0}};
        end else if (latch_s) begin
            lat_we_r    <= u_we;
            lat_be_r    <= u_be;
            lat_addr_r  <= u_addr;
            lat_wdata_r <= u_wdata;
        end else begin
            lat_we_r    <= lat_we_r;
            lat_be_r    <= lat_be_r;
            lat_addr_r  <= lat_addr_r;
            lat_wdata_r <= lat_wdata_r;
        end
    end

    // RAM port mux and handshake outputs, decoded from the current state.
    always_comb begin
        c_gnt     = 1'b0;
        u_ack     = 1'b0;
        u_rdata   = {DATA_W{1'b0}};
        ram_en    = 1'b0;
        ram_we    = {BE_W{1'b0}};
        ram_addr  = {ADDR_W{1'b0}};
        ram_wdata = {DATA_W{1'b0}};
        case (state_r)
            CACHE: begin
                c_gnt     = 1'b1;
                ram_en    = c_req;
                ram_addr  = c_addr;
                ram_wdata = c_wdata;
                if (c_req && c_we) begin
                    ram_we = {BE_W{1'b1}};
                end else begin
                    ram_we = {BE_W{1'b0}};
                end
            end
            U_ISSUE: begin
                ram_en    = 1'b1;
                ram_addr  = lat_addr_r;
                ram_wdata = lat_wdata_r;
                if (lat_we_r) begin
                    ram_we = lat_be_r;
                end else begin
                    ram_we = {BE_W{1'b0}};
                end
            end
            U_RESP: begin
                u_ack = 1'b1;
                if (lat_we_r) begin
                    u_rdata = {DATA_W{1'b0}};
                end else begin
                    u_rdata = ram_rdata;
                end
            end
            default: begin
                c_gnt = 1'b0;
            end
        endcase
    end

    // Cache read-data valid, one cycle behind the issued read beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_rvalid_r <= 1'b0;
        end else begin
            c_rvalid_r <= c_req & ~c_we & c_gnt;
        end
    end

    assign c_rvalid = c_rvalid_r;

endmodule
